// File: rtl/tdc_seq_pkg.sv
// tdc_seq_pkg: shared state encoding and FIFO entry layout for the TDC sequencer.
// The entry carries per-burst min/max when TDC_SEQ_MINMAX_EN is defined.
package tdc_seq_pkg;

    localparam int unsigned TDC_TIME_W = 20;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT,
        GAP,
        PUSH
    } seq_state_t;

    typedef struct packed {
`ifdef TDC_SEQ_MINMAX_EN
        logic [TDC_TIME_W-1:0] t_max;
        logic [TDC_TIME_W-1:0] t_min;
`endif
        logic [TDC_TIME_W-1:0] avg;
    } tdc_res_t;

endpackage

// File: rtl/tdc_res_fifo.sv
// tdc_res_fifo: first-word-fall-through result FIFO with occupancy level.
// DEPTH must be a power of two so the pointers wrap naturally.
module tdc_res_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     pll_clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_wr;
    logic             w_rd;

    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    // Storage is reset too so the head reads as zero while empty.
    always_ff @(posedge pll_clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/tdc_meas_seq.sv
// tdc_meas_seq: arms the TDC, collects 2^AVG_LOG2 samples per burst with timeout,
// and queues the truncated average. Optional per-burst min/max: TDC_SEQ_MINMAX_EN.
module tdc_meas_seq
    import tdc_seq_pkg::*;
#(
    parameter int unsigned TIME_W     = TDC_TIME_W,
    parameter int unsigned AVG_LOG2   = 2,
    parameter int unsigned TMO_W      = 16,
    parameter int unsigned GAP_W      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          pll_clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [TMO_W-1:0]              cfg_timeout,
    input  logic [GAP_W-1:0]              cfg_gap,
    output logic                          tdc_mod,
    input  logic [TIME_W-1:0]             tdc_time,
    input  logic                          tdc_dval,
    output logic                          busy,
    output logic                          err_timeout,
    output logic [TIME_W-1:0]             res_data,
    output logic [TIME_W-1:0]             res_min,
    output logic [TIME_W-1:0]             res_max,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int unsigned      ACC_W    = TIME_W + AVG_LOG2;
    localparam int unsigned      SMP_W    = AVG_LOG2 + 1;
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);

    seq_state_t        r_state;
    seq_state_t        w_next;
    logic              r_mod;
    logic              r_busy;
    logic              r_err;
    logic              w_mod_nxt;
    logic              w_busy_nxt;
    logic              w_err_nxt;
    logic [TMO_W-1:0]  r_timer;
    logic              r_tmo_en;
    logic [GAP_W-1:0]  r_gap;
    logic [SMP_W-1:0]  r_smp;
    logic [ACC_W-1:0]  r_acc;
    logic              w_dval;
    logic              w_expire;
    logic              w_burst_start;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    tdc_res_t          w_wr_res;
    tdc_res_t          w_rd_res;

    assign w_dval        = (r_state == WAIT) && tdc_dval;
    // Expiry is judged on the cycle the timer would reach zero; a dval there wins.
    assign w_expire      = (r_state == WAIT) && r_tmo_en && (r_timer == TMO_W'(1)) && !tdc_dval;
    assign w_burst_start = (r_state == IDLE) && start && !abort;
    assign w_push        = (r_state == PUSH) && !w_full && !abort;

    always_ff @(posedge pll_clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_mod   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_mod   <= w_mod_nxt;
            r_busy  <= w_busy_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_burst_start) w_next = ARM;
            ARM:  w_next = WAIT;
            WAIT: begin
                if (w_dval) begin
                    w_next = (r_smp == SMP_LAST) ? PUSH : GAP;
                end else if (w_expire) begin
                    w_next = IDLE;
                end
            end
            GAP:  if (r_gap == cfg_gap) w_next = ARM;
            PUSH: if (!w_full) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (abort) begin
            w_next = IDLE;
        end
    end

    always_comb begin
        w_mod_nxt  = (w_next == ARM) || (w_next == WAIT);
        w_busy_nxt = (w_next != IDLE);
        w_err_nxt  = w_expire && !abort;
    end

    always_ff @(posedge pll_clk or negedge rst) begin
        if (!rst) begin
            r_timer  <= '0;
            r_tmo_en <= 1'b0;
            r_gap    <= '0;
            r_smp    <= '0;
            r_acc    <= '0;
        end else begin
            r_gap <= (r_state == GAP) ? r_gap + GAP_W'(1) : '0;
            if (w_burst_start) begin
                r_acc <= '0;
                r_smp <= '0;
            end else if (w_dval) begin
                r_acc <= r_acc + ACC_W'(tdc_time);
                r_smp <= r_smp + SMP_W'(1);
            end
            if (r_state == ARM) begin
                r_timer  <= cfg_timeout;
                r_tmo_en <= (cfg_timeout != '0);
            end else if ((r_state == WAIT) && r_tmo_en) begin
                r_timer <= r_timer - TMO_W'(1);
            end
        end
    end

`ifdef TDC_SEQ_MINMAX_EN
    logic [TIME_W-1:0] r_min;
    logic [TIME_W-1:0] r_max;

    always_ff @(posedge pll_clk or negedge rst) begin
        if (!rst) begin
            r_min <= '1;
            r_max <= '0;
        end else if (w_burst_start) begin
            r_min <= '1;
            r_max <= '0;
        end else if (w_dval) begin
            if (tdc_time < r_min) r_min <= tdc_time;
            if (tdc_time > r_max) r_max <= tdc_time;
        end
    end

    always_comb begin
        w_wr_res       = '0;
        w_wr_res.avg   = r_acc[ACC_W-1:AVG_LOG2];
        w_wr_res.t_min = r_min;
        w_wr_res.t_max = r_max;
    end

    assign res_min = w_rd_res.t_min;
    assign res_max = w_rd_res.t_max;
`else
    always_comb begin
        w_wr_res     = '0;
        w_wr_res.avg = r_acc[ACC_W-1:AVG_LOG2];
    end

    assign res_min = '0;
    assign res_max = '0;
`endif

    tdc_res_fifo #(
        .WIDTH ($bits(tdc_res_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .pll_clk   (pll_clk),
        .rst       (rst),
        .i_wr_en   (w_push),
        .i_wr_data (w_wr_res),
        .i_rd_en   (res_ready),
        .o_rd_data (w_rd_res),
        .o_level   (fifo_level),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign tdc_mod     = r_mod;
    assign busy        = r_busy;
    assign err_timeout = r_err;
    assign res_data    = w_rd_res.avg;
    assign res_valid   = !w_empty;

endmodule

// File: tb/tb_tdc_meas_seq.sv
// tb_tdc_meas_seq: directed, table-driven bench for tdc_meas_seq.
// Expects min/max values when built with TDC_SEQ_MINMAX_EN, zeros otherwise.
module tb_tdc_meas_seq;
    import tdc_seq_pkg::*;

    localparam int unsigned TW    = 20;
    localparam int unsigned TMO_W = 16;
    localparam int unsigned GAP_W = 8;
    localparam int unsigned FD    = 4;
`ifdef TDC_SEQ_MINMAX_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif

    logic             pll_clk = 1'b0;
    logic             rst     = 1'b1;
    logic             start   = 1'b0;
    logic             abort   = 1'b0;
    logic [TMO_W-1:0] cfg_timeout = '0;
    logic [GAP_W-1:0] cfg_gap     = '0;
    logic             tdc_mod;
    logic [TW-1:0]    tdc_time = '0;
    logic             tdc_dval = 1'b0;
    logic             busy;
    logic             err_timeout;
    logic [TW-1:0]    res_data;
    logic [TW-1:0]    res_min;
    logic [TW-1:0]    res_max;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [$clog2(FD):0] fifo_level;

    int total   = 0;
    int bad     = 0;
    int err_cnt = 0;

    tdc_meas_seq #(
        .TIME_W     (TW),
        .AVG_LOG2   (2),
        .TMO_W      (TMO_W),
        .GAP_W      (GAP_W),
        .FIFO_DEPTH (FD)
    ) dut (
        .pll_clk     (pll_clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .cfg_timeout (cfg_timeout),
        .cfg_gap     (cfg_gap),
        .tdc_mod     (tdc_mod),
        .tdc_time    (tdc_time),
        .tdc_dval    (tdc_dval),
        .busy        (busy),
        .err_timeout (err_timeout),
        .res_data    (res_data),
        .res_min     (res_min),
        .res_max     (res_max),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .fifo_level  (fifo_level)
    );

    always #5 pll_clk = ~pll_clk;

    always @(negedge pll_clk) begin
        if (err_timeout) err_cnt++;
    end

    typedef logic [3:0][TW-1:0] smp4_t;

    typedef struct {
        smp4_t s;
        int    gap;
        int    tmo;
        int    extra;
        int    avg;
        int    mn;
        int    mx;
    } vec_t;

    vec_t tbl[7];

    function automatic smp4_t s4(input int a, input int b, input int c, input int d);
        smp4_t r;
        r[0] = TW'(a);
        r[1] = TW'(b);
        r[2] = TW'(c);
        r[3] = TW'(d);
        return r;
    endfunction

    function automatic vec_t mk(input smp4_t s, input int gap, input int tmo, input int extra,
                                input int avg, input int mn, input int mx);
        vec_t v;
        v.s     = s;
        v.gap   = gap;
        v.tmo   = tmo;
        v.extra = extra;
        v.avg   = avg;
        v.mn    = MM ? mn : 0;
        v.mx    = MM ? mx : 0;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge pll_clk);
        #1;
    endtask

    // Runs a burst delivering n samples; returns just after the last dval edge.
    task automatic burst(input smp4_t s, input int n, input int gap, input int tmo, input int extra);
        int lows;
        cfg_gap     = GAP_W'(gap);
        cfg_timeout = TMO_W'(tmo);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            lows = 0;
            while (!tdc_mod && lows < 600) begin
                tick();
                lows++;
            end
            check("mod_rise", 32'(tdc_mod), 1);
            if (k > 0) check("gap_low_cycles", lows, gap + 1);
            repeat (1 + extra) tick();
            check("mod_in_wait", 32'(tdc_mod), 1);
            tdc_time = s[k];
            tdc_dval = 1'b1;
            tick();
            tdc_dval = 1'b0;
        end
    endtask

    task automatic pop();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int err_base;

        tbl[0] = mk(s4(100, 200, 300, 401),              2, 100,  0, 250, 100, 401);
        tbl[1] = mk(s4(0, 0, 0, 0),                      0, 100,  0,   0,   0,   0);
        tbl[2] = mk(s4(1, 1, 1, 2),                      1, 100,  0,   1,   1,   2);
        tbl[3] = mk(s4(1048575, 1048575, 1048575, 1048575), 3, 100, 0, 1048575, 1048575, 1048575);
        tbl[4] = mk(s4(7, 3, 9, 5),                      0,   0, 30,   6,   3,   9);
        tbl[5] = mk(s4(3, 0, 0, 0),                      1,   5,  4,   0,   0,   3);
        tbl[6] = mk(s4(8, 6, 4, 2),                      0,   1,  0,   5,   2,   8);

        #2 rst = 1'b0;
        #10;
        check("rst_mod",   32'(tdc_mod),     0);
        check("rst_busy",  32'(busy),        0);
        check("rst_err",   32'(err_timeout), 0);
        check("rst_valid", 32'(res_valid),   0);
        check("rst_data",  32'(res_data),    0);
        check("rst_level", 32'(fifo_level),  0);
        @(negedge pll_clk) rst = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            burst(tbl[i].s, 4, tbl[i].gap, tbl[i].tmo, tbl[i].extra);
            check("push_busy",     32'(busy),      1);
            check("push_notvalid", 32'(res_valid), 0);
            tick();
            check("res_valid", 32'(res_valid),  1);
            check("idle_busy", 32'(busy),       0);
            check("level_one", 32'(fifo_level), 1);
            check("avg",       32'(res_data),   tbl[i].avg);
            check("min",       32'(res_min),    tbl[i].mn);
            check("max",       32'(res_max),    tbl[i].mx);
            pop();
            check("level_after_pop", 32'(fifo_level), 0);
        end
        check("no_err_in_table", err_cnt, 0);

        // Timeout with no dval: pulse lands six cycles after ARM.
        cfg_timeout = TMO_W'(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("tmo_arm_mod", 32'(tdc_mod), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("tmo_early_err", 32'(err_timeout), 0);
            check("tmo_early_busy", 32'(busy), 1);
        end
        tick();
        check("tmo_err_pulse", 32'(err_timeout), 1);
        check("tmo_busy_low",  32'(busy),        0);
        check("tmo_mod_low",   32'(tdc_mod),     0);
        tick();
        check("tmo_err_1cyc",  32'(err_timeout), 0);
        check("tmo_no_entry",  32'(fifo_level),  0);
        check("tmo_err_count", err_cnt,          1);
        err_base = err_cnt;

        // FIFO full: fifth result waits in PUSH until a pop frees a slot.
        for (int b = 0; b < 4; b++) begin
            burst(s4(10 * (b + 1), 10 * (b + 1), 10 * (b + 1), 10 * (b + 1)), 4, 0, 100, 0);
            tick();
            check("fill_level", 32'(fifo_level), b + 1);
        end
        burst(s4(50, 50, 50, 50), 4, 0, 100, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_hold_busy",  32'(busy),       1);
            check("full_hold_level", 32'(fifo_level), 4);
        end
        check("full_head", 32'(res_data), 10);
        pop();
        check("full_pop_level", 32'(fifo_level), 3);
        check("full_pop_busy",  32'(busy),       1);
        tick();
        check("full_late_push_level", 32'(fifo_level), 4);
        check("full_late_push_busy",  32'(busy),       0);
        for (int e = 0; e < 4; e++) begin
            check("drain_order", 32'(res_data), 20 + 10 * e);
            pop();
        end
        check("drain_empty", 32'(res_valid), 0);
        pop();
        check("pop_on_empty", 32'(fifo_level), 0);

        // Abort in WAIT after two samples.
        burst(s4(1000, 1000, 0, 0), 2, 1, 100, 0);
        for (int i = 0; i < 600 && !tdc_mod; i++) tick();
        check("abort_rearm", 32'(tdc_mod), 1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy),    0);
        check("abort_mod",  32'(tdc_mod), 0);
        tick();
        check("abort_no_entry", 32'(fifo_level), 0);
        check("abort_no_err",   err_cnt,         err_base);
        burst(s4(4, 8, 12, 16), 4, 0, 100, 0);
        tick();
        check("post_abort_avg", 32'(res_data), 10);
        check("post_abort_min", 32'(res_min),  MM ? 4 : 0);
        check("post_abort_max", 32'(res_max),  MM ? 16 : 0);
        pop();

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", 32'(busy),    0);
        check("start_abort_mod",  32'(tdc_mod), 0);

        // Asynchronous reset in the middle of a burst with an entry queued.
        burst(s4(5, 5, 5, 5), 4, 0, 100, 0);
        tick();
        check("pre_rst_level", 32'(fifo_level), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("mid_rst_level", 32'(fifo_level), 0);
        check("mid_rst_valid", 32'(res_valid),  0);
        check("mid_rst_mod",   32'(tdc_mod),    0);
        check("mid_rst_busy",  32'(busy),       0);
        @(negedge pll_clk) rst = 1'b1;
        tick();
        check("post_rst_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
